md_unit: RTL and testbench

Multiply/divide unit of the EX stage, upstream of the memory stage of the five-stage MIPS pipeline. Accepts mult/multu/div/divu/mthi/mtlo from the EX stage and models fixed multi-cycle latency with a registered busy flag, which the hazard unit uses to stall. Owns the HI/LO architectural registers. mfhi/mflo read `hi`/`lo` directly, and that result travels down the pipe like any ALU result.

---
 rtl/md_pkg.sv | 45 ++++
 rtl/md_unit_if.sv | 21 ++
 rtl/md_calc.sv | 75 +++++++
 rtl/md_unit.sv | 91 +++++++++
 tb/tb_md_unit.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared constants for the multiply/divide unit: op codes, default latencies, op classifiers.
// The accumulate ops are classified as multiply-class only when MD_MADD_EN is defined.
package md_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8,
    MD_MSUB  = 4'd9,
    MD_MSUBU = 4'd10
  } md_op_e;

  localparam int MD_MULT_LAT_DEF = 5;
  localparam int MD_DIV_LAT_DEF  = 10;

  function automatic logic md_is_mul(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_MULT, MD_MULTU: r = 1'b1;
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic md_is_div(input logic [3:0] op);
    logic r;
    r = 1'b0;
    case (op)
      MD_DIV, MD_DIVU: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage <-> multiply/divide unit connection: issue signals in, busy and HI/LO out.
interface md_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_data, rt_data, req,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, req,
    output busy, hi, lo
  );
endinterface

// File: rtl/md_calc.sv
// Combinational multiply/divide datapath: 64-bit {hi,lo} result plus divide-by-zero flag.
// With MD_MADD_EN defined the current hi/lo feed an accumulate adder.
import md_pkg::*;

module md_calc (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef MD_MADD_EN
  input  logic [31:0] hi,
  input  logic [31:0] lo,
`endif
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0]        prod_s_s;
  logic [63:0]        prod_u_s;
  logic               b_zero_s;
  logic               s_ovf_s;
  logic signed [31:0] s_num_s;
  logic signed [31:0] s_den_s;
  logic signed [31:0] s_quo_s;
  logic signed [31:0] s_rem_s;
  logic [31:0]        u_den_s;
  logic [31:0]        u_quo_s;
  logic [31:0]        u_rem_s;

  assign prod_s_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u_s = {32'd0, a} * {32'd0, b};

  // Divisors are steered away from zero and from INT_MIN / -1 so the divider never traps.
  assign b_zero_s = (b == 32'd0);
  assign s_ovf_s  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign s_num_s  = a;
  assign s_den_s  = (b_zero_s || s_ovf_s) ? 32'sd1 : b;
  assign s_quo_s  = s_num_s / s_den_s;
  assign s_rem_s  = s_num_s % s_den_s;
  assign u_den_s  = b_zero_s ? 32'd1 : b;
  assign u_quo_s  = a / u_den_s;
  assign u_rem_s  = a % u_den_s;

  // Result select by op; {hi,lo} ordering with hi in the upper word.
  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      MD_MULT:  result = prod_s_s;
      MD_MULTU: result = prod_u_s;
      MD_DIV: begin
        div_zero = b_zero_s;
        if (s_ovf_s) begin
          result = {32'd0, 32'h8000_0000};
        end else begin
          result = {s_rem_s, s_quo_s};
        end
      end
      MD_DIVU: begin
        div_zero = b_zero_s;
        result   = {u_rem_s, u_quo_s};
      end
`ifdef MD_MADD_EN
      MD_MADD:  result = {hi, lo} + prod_s_s;
      MD_MADDU: result = {hi, lo} + prod_u_s;
      MD_MSUB:  result = {hi, lo} - prod_s_s;
      MD_MSUBU: result = {hi, lo} - prod_u_s;
`endif
      default: begin
        result   = 64'd0;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: owns HI/LO, models fixed latency with a down-counter and busy flag.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MD_MADD_EN.
import md_pkg::*;

module md_unit #(
  parameter int MULT_LAT = MD_MULT_LAT_DEF,
  parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
  input logic        clk,
  input logic        rst,
  md_unit_if.slave   md
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic [31:0]      res_hi_r;
  logic [31:0]      res_lo_r;
  logic             dz_r;
  logic             accept_s;
  logic [63:0]      calc_res_s;
  logic             calc_dz_s;

  assign accept_s = md.start & ~md.req & ~busy_r;

  md_calc u_calc (
    .op       (md.op),
    .a        (md.rs_data),
    .b        (md.rt_data),
`ifdef MD_MADD_EN
    .hi       (hi_r),
    .lo       (lo_r),
`endif
    .result   (calc_res_s),
    .div_zero (calc_dz_s)
  );

  // Accept/issue, latency countdown and HI/LO commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      res_hi_r <= 32'd0;
      res_lo_r <= 32'd0;
      dz_r     <= 1'b0;
    end else if (accept_s) begin
      if (md_is_mul(md.op)) begin
        res_hi_r <= calc_res_s[63:32];
        res_lo_r <= calc_res_s[31:0];
        dz_r     <= 1'b0;
        cnt_r    <= CNT_W'(MULT_LAT);
        busy_r   <= 1'b1;
      end else if (md_is_div(md.op)) begin
        res_hi_r <= calc_res_s[63:32];
        res_lo_r <= calc_res_s[31:0];
        dz_r     <= calc_dz_s;
        cnt_r    <= CNT_W'(DIV_LAT);
        busy_r   <= 1'b1;
      end else if (md.op == MD_MTHI) begin
        hi_r <= md.rs_data;
      end else if (md.op == MD_MTLO) begin
        lo_r <= md.rs_data;
      end else begin
        cnt_r <= cnt_r;
      end
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - CNT_W'(1);
      // Final countdown edge: results become architectural unless the divisor was zero.
      if (cnt_r == CNT_W'(1)) begin
        busy_r <= 1'b0;
        if (!dz_r) begin
          hi_r <= res_hi_r;
          lo_r <= res_lo_r;
        end
      end
    end else begin
      busy_r <= 1'b0;
    end
  end

  assign md.busy = busy_r;
  assign md.hi   = hi_r;
  assign md.lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; inputs change and outputs are sampled on negedge.
module tb_md_unit;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n;

  md_unit_if md_if ();

  md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk (clk),
    .rst (rst),
    .md  (md_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one start pulse for a cycle; returns at the negedge of the first cycle after accept.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic rq);
    md_if.start   = 1'b1;
    md_if.op      = op;
    md_if.rs_data = a;
    md_if.rt_data = b;
    md_if.req     = rq;
    @(negedge clk);
    md_if.start   = 1'b0;
    md_if.req     = 1'b0;
    md_if.op      = 4'd0;
  endtask

  // Count consecutive busy cycles, bounded; returns at the first negedge with busy low.
  task automatic busy_len(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (md_if.busy !== 1'b1) break;
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    md_if.start   = 1'b0;
    md_if.op      = 4'd0;
    md_if.rs_data = 32'd0;
    md_if.rt_data = 32'd0;
    md_if.req     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {31'd0, md_if.busy}, 32'd0);
    check("reset_hi", md_if.hi, 32'd0);
    check("reset_lo", md_if.lo, 32'd0);

    // MULT -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    busy_len(n);
    check("mult_busy_len", n, 32'd5);
    check("mult_hi", md_if.hi, 32'hFFFF_FFFF);
    check("mult_lo", md_if.lo, 32'hFFFF_FFFA);

    // MULTU issued back-to-back in the first idle cycle
    issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    busy_len(n);
    check("multu_busy_len", n, 32'd5);
    check("multu_hi", md_if.hi, 32'hFFFF_FFFE);
    check("multu_lo", md_if.lo, 32'h0000_0001);

    // DIV -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    busy_len(n);
    check("div_busy_len", n, 32'd10);
    check("div_lo", md_if.lo, 32'hFFFF_FFFD);
    check("div_hi", md_if.hi, 32'hFFFF_FFFF);

    // DIVU 7 / 0: full latency, HI/LO untouched
    issue(4'd4, 32'd7, 32'd0, 1'b0);
    busy_len(n);
    check("divz_busy_len", n, 32'd10);
    check("divz_hi", md_if.hi, 32'hFFFF_FFFF);
    check("divz_lo", md_if.lo, 32'hFFFF_FFFD);

    // DIV overflow case
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    busy_len(n);
    check("divovf_lo", md_if.lo, 32'h8000_0000);
    check("divovf_hi", md_if.hi, 32'd0);

    // DIVU large unsigned
    issue(4'd4, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0);
    busy_len(n);
    check("divu_lo", md_if.lo, 32'h0FFF_FFFF);
    check("divu_hi", md_if.hi, 32'h0000_000F);

    // MTHI visible next cycle, no busy
    issue(4'd5, 32'h1234_5678, 32'd0, 1'b0);
    check("mthi_hi", md_if.hi, 32'h1234_5678);
    check("mthi_busy", {31'd0, md_if.busy}, 32'd0);

    // MULT cancelled by req
    issue(4'd1, 32'd2, 32'd3, 1'b1);
    check("req_busy", {31'd0, md_if.busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("req_hi", md_if.hi, 32'h1234_5678);
    check("req_lo", md_if.lo, 32'h0FFF_FFFF);

    // Unknown op ignored
    issue(4'd15, 32'd9, 32'd9, 1'b0);
    check("unk_busy", {31'd0, md_if.busy}, 32'd0);
    check("unk_lo", md_if.lo, 32'h0FFF_FFFF);

    // MTLO
    issue(4'd6, 32'hCAFE_F00D, 32'd0, 1'b0);
    check("mtlo_lo", md_if.lo, 32'hCAFE_F00D);

    // Reset during busy cycle 3 aborts the operation
    issue(4'd1, 32'd2, 32'd3, 1'b0);
    check("rstmid_busy1", {31'd0, md_if.busy}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_busy", {31'd0, md_if.busy}, 32'd0);
    check("rstmid_hi", md_if.hi, 32'd0);
    check("rstmid_lo", md_if.lo, 32'd0);
    repeat (6) @(negedge clk);
    check("rstmid_late_lo", md_if.lo, 32'd0);
    check("rstmid_late_busy", {31'd0, md_if.busy}, 32'd0);

    // MTLO 10 then MADD 4 x 5
    issue(4'd6, 32'd10, 32'd0, 1'b0);
    issue(4'd7, 32'd4, 32'd5, 1'b0);
`ifdef MD_MADD_EN
    busy_len(n);
    check("madd_busy_len", n, 32'd5);
    check("madd_hi", md_if.hi, 32'd0);
    check("madd_lo", md_if.lo, 32'd30);
`else
    check("madd_off_busy", {31'd0, md_if.busy}, 32'd0);
    repeat (6) @(negedge clk);
    check("madd_off_lo", md_if.lo, 32'd10);
    check("madd_off_hi", md_if.hi, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
